// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: registered N:1 select stage with a two-entry elastic buffer.
// The main register drives the outputs; the skid register catches the one
// extra entry that can arrive while the consumer stalls.
module sel_mux_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_bad_sel,
    output logic [1:0]               level
);

    // The state encoding equals the number of buffered entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              main_bad_q, main_bad_d;
    logic              skid_bad_q, skid_bad_d;
    logic [DATA_W-1:0] chosen_data;
    logic              chosen_bad;
    logic              accept;
    logic              pop;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = main_data_q;
    assign out_bad_sel = main_bad_q;
    assign level       = state_q;
    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    // Pick the requested input; an index of NUM_IN or above gives zero data and a bad flag.
    always_comb begin
        chosen_data = '0;
        chosen_bad  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                chosen_data = in_data[k*DATA_W +: DATA_W];
                chosen_bad  = 1'b0;
            end
        end
    end

    // Next buffer state; flush empties the stage and drops any entry offered in the same cycle.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_bad_d  = main_bad_q;
        skid_data_d = skid_data_q;
        skid_bad_d  = skid_bad_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = chosen_data;
                        main_bad_d  = chosen_bad;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_d = chosen_data;
                        main_bad_d  = chosen_bad;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_data_d = chosen_data;
                        skid_bad_d  = chosen_bad;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_bad_d  = skid_bad_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and storage registers; reset clears everything so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_bad_q  <= 1'b0;
            skid_data_q <= '0;
            skid_bad_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_bad_q  <= main_bad_d;
            skid_data_q <= skid_data_d;
            skid_bad_q  <= skid_bad_d;
        end
    end

endmodule

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

- Parametrised, registered N:1 select stage for the RISC-V datapath.
- Generalises the fixed 3:1 combinational result/forwarding mux:
  - configurable data width and input count;
  - explicit out-of-range select flagging;
  - a two-entry elastic buffer with valid/ready handshake and synchronous flush.
- Sits between execute-stage source selection and the next pipeline register, so a stalled consumer never loses a selected operand.

## Interface
- DATA_W, 32, width of each data input and of the output.
- NUM_IN, 3, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream offers a select/data set this cycle.
- in_ready  output  1  stage can accept this cycle.
- in_sel  input  SEL_W  index of the input to forward.
- in_data  input  NUM_IN*DATA_W  packed inputs; input k is in_data[k*DATA_W +: DATA_W].
- out_valid  output  1  out_data/out_bad_sel hold a valid entry.
- out_ready  input  1  downstream consumes the entry when out_valid is high.
- out_data  output  DATA_W  selected data.
- out_bad_sel  output  1  entry was captured with in_sel >= NUM_IN.
- level  output  2  buffered entries: 0, 1 or 2.

## Operation
- Selection is combinational on the input side.
  - When in_sel < NUM_IN: chosen = input in_sel, bad = 0.
  - Otherwise: chosen = 0, bad = 1.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage is a main register (drives outputs) and a skid register.
- States are encoded by level:
  - EMPTY (level 0): out_valid=0, in_ready=1.
    - accept -> ONE, main <= chosen/bad.
  - ONE (level 1): out_valid=1, in_ready=1.
    - accept & pop -> ONE, main <= new entry.
    - accept & !pop -> FULL, skid <= new entry, main unchanged.
    - pop & !accept -> EMPTY.
    - neither -> hold.
  - FULL (level 2): out_valid=1, in_ready=0.
    - pop -> ONE, main <= skid.
    - no pop -> hold.
- in_ready is a function of registered state only (level != 2). It never depends combinationally on out_ready.
- flush has priority over everything:
  - next state EMPTY, level 0, out_valid 0;
  - any entry accepted in the flush cycle is discarded;
  - a pop in the flush cycle still counts as consumed by downstream.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- out_data and out_bad_sel are stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, any time, including mid-transfer): immediately and asynchronously
  - out_valid=0, out_data=0, out_bad_sel=0, level=0, in_ready=1;
  - skid contents cleared to 0.
- First accept is possible in the first clk edge after rst_n deasserts.
- Latency: an entry accepted at edge N is on out_valid/out_data after edge N when the stage was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: one entry per cycle sustained while out_ready=1.
- Backpressure: one cycle of out_ready=0 absorbs exactly one extra entry. in_ready drops the cycle after FULL is reached.
- In FULL, a pop at edge N gives in_ready=1 after edge N. Accepting again in that same cycle is not possible.
- After flush at edge N: out_valid=0 and in_ready=1 after edge N.

## Test plan
- Reset and basic select:
  - stimulus: NUM_IN=3, in_data={C,B,A}={0x33333333,0x22222222,0x11111111}, in_sel=1, in_valid=1, out_ready=1;
  - response: next cycle out_valid=1, out_data=0x22222222, out_bad_sel=0, level=1.
- Bad select:
  - stimulus: in_sel=3 with NUM_IN=3;
  - response: out_data=0x00000000, out_bad_sel=1.
- Backpressure:
  - stimulus: stream sel 0,1,2,0 with out_ready=0 from cycle 2;
  - response: level reaches 2, in_ready=0, out_data held at first entry (0x11111111).
  - then raise out_ready: entries emerge in order 0x11111111, 0x22222222, 0x33333333, 0x11111111 with none lost.
- Flush:
  - stimulus: FULL state with flush=1 and in_valid=1 on the same edge;
  - response: next cycle level=0, out_valid=0, in_ready=1; the concurrent input never appears at the output.
- Async reset mid-stream:
  - stimulus: drop rst_n between clk edges while level=2;
  - response: outputs clear to 0 before the next edge; the stage resumes accepting after release.
- Parameter sweep:
  - stimulus: DATA_W=64, NUM_IN=5, SEL_W=3, random valid/ready over 10k cycles against a scoreboard;
  - response: no mismatches; out_bad_sel=1 exactly for in_sel 5..7.
